// File: rtl/pipe_cla_add_pkg.sv
// Shared constants and the slice-to-stage mapping for the pipelined lookahead adder.
package pipe_cla_add_pkg;

  localparam int unsigned DefaultWidth  = 32;
  localparam int unsigned DefaultStages = 4;
  localparam int unsigned SliceWidth    = 4;

  // Slices are spread evenly so every stage owns at least one slice when stages <= slices.
  function automatic int unsigned slice_stage(input int unsigned k, input int unsigned stages,
                                              input int unsigned slices);
    return (k * stages) / slices;
  endfunction

endpackage

// File: rtl/pipe_cla_add_cla4.sv
// 4-bit carry-lookahead slice; c3 exposes the carry into the top bit for overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
              (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipe_cla_add.sv
// Pipelined add/subtract built from 4-bit lookahead slices, with valid/ready flow control.
module pipe_cla_add
  import pipe_cla_add_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned Slices = WIDTH / SliceWidth;

  logic adv;

  // Operands, partial sum and carry as seen at the input of each stage.
  logic [WIDTH-1:0] a_src      [STAGES];
  logic [WIDTH-1:0] b_src      [STAGES];
  logic [WIDTH-1:0] s_src      [STAGES];
  logic             carry_src  [STAGES];
  logic             valid_src  [STAGES];

  logic [WIDTH-1:0] s_next     [STAGES];
  logic             carry_next [STAGES];

  logic             valid_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ov_q;

  assign adv      = ~(valid_q & ~out_ready);
  assign in_ready = adv;

  // Subtract is a + ~b + ~ci, so invert b and the borrow once on entry.
  assign a_src[0]     = a;
  assign b_src[0]     = sub ? ~b : b;
  assign s_src[0]     = '0;
  assign carry_src[0] = sub ? ~ci : ci;
  assign valid_src[0] = in_valid;

  for (genvar k = 0; k < Slices; k++) begin : g_slice
    localparam int unsigned St = slice_stage(k, STAGES, Slices);

    logic [3:0] s_w;
    logic       ci_w;
    logic       co_w;
    logic       c3_w;

    // The first slice of a stage takes the registered carry; others ripple within the stage.
    if (k == 0) begin : g_cin
      assign ci_w = carry_src[0];
    end else if (slice_stage(k - 1, STAGES, Slices) != St) begin : g_cin
      assign ci_w = carry_src[St];
    end else begin : g_cin
      assign ci_w = g_slice[k-1].co_w;
    end

    cla4_slice u_slice (
      .a  (a_src[St][SliceWidth*k +: SliceWidth]),
      .b  (b_src[St][SliceWidth*k +: SliceWidth]),
      .ci (ci_w),
      .s  (s_w),
      .co (co_w),
      .c3 (c3_w)
    );

    if (k == Slices - 1) begin : g_tail
      assign carry_next[St] = co_w;
    end else if (slice_stage(k + 1, STAGES, Slices) != St) begin : g_tail
      assign carry_next[St] = co_w;
    end
  end

  for (genvar st = 0; st < STAGES; st++) begin : g_stage
    // Merge this stage's freshly computed nibbles into the delayed partial sum.
    for (genvar k = 0; k < Slices; k++) begin : g_bits
      if (slice_stage(k, STAGES, Slices) == st) begin : g_new
        assign s_next[st][SliceWidth*k +: SliceWidth] = g_slice[k].s_w;
      end else begin : g_old
        assign s_next[st][SliceWidth*k +: SliceWidth] = s_src[st][SliceWidth*k +: SliceWidth];
      end
    end

    if (st < STAGES - 1) begin : g_mid
      logic             v_r;
      logic             c_r;
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] s_r;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_r <= 1'b0;
          c_r <= 1'b0;
          a_r <= '0;
          b_r <= '0;
          s_r <= '0;
        end else if (adv) begin
          v_r <= valid_src[st];
          c_r <= carry_next[st];
          a_r <= a_src[st];
          b_r <= b_src[st];
          s_r <= s_next[st];
        end
      end

      assign valid_src[st+1] = v_r;
      assign carry_src[st+1] = c_r;
      assign a_src[st+1]     = a_r;
      assign b_src[st+1]     = b_r;
      assign s_src[st+1]     = s_r;
    end else begin : g_last
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          s_q     <= '0;
          co_q    <= 1'b0;
          ov_q    <= 1'b0;
        end else if (adv) begin
          valid_q <= valid_src[st];
          s_q     <= s_next[st];
          co_q    <= carry_next[st];
          ov_q    <= g_slice[Slices-1].c3_w ^ carry_next[st];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_pipe_cla_add.sv
// Directed and scoreboarded checks of pipe_cla_add, plus a small width/stage sweep.
module tb_pipe_cla_add;

  typedef struct {
    logic [65:0] exp;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co;
  logic        ov;

  logic        sw_valid;
  logic [63:0] sw_a;
  logic [63:0] sw_b;
  logic        sw_ci;
  logic        sw_sub;
  logic        sw_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  logic [65:0] mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] ra, input logic [63:0] rb,
                                          input logic rci, input logic rsub);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] ss;
    logic        cc;
    logic        rco;
    logic        rov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = ra & mask;
    bb   = (rsub ? ~rb : rb) & mask;
    cc   = rsub ? ~rci : rci;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, cc};
    ss   = full[63:0] & mask;
    rco  = full[w];
    rov  = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    return {rov, rco, ss};
  endfunction

  pipe_cla_add #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  always @(negedge clk) begin
    logic [65:0] e;
    if (!reset) begin
      if (in_valid && in_ready) mq.push_back(ref_add(32, {32'd0, a}, {32'd0, b}, ci, sub));
      if (out_valid && out_ready) begin
        if (mq.size() == 0) begin
          check("main_extra", 128'(1), 128'(0));
        end else begin
          e = mq.pop_front();
          check("main_res", 128'({ov, co, s}), 128'({e[65:64], e[31:0]}));
          n_out++;
        end
      end
    end
  end

  function automatic int sw_w(input int i);
    case (i)
      0, 1:    return 8;
      2, 3:    return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int sw_s(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : g_sw
    localparam int W = sw_w(gi);
    localparam int S = sw_s(gi);

    logic         v_o;
    logic         rdy_o;
    logic         co_o;
    logic         ov_o;
    logic [W-1:0] s_o;
    sb_t          q[$];

    pipe_cla_add #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (sw_valid),
      .in_ready  (rdy_o),
      .a         (sw_a[W-1:0]),
      .b         (sw_b[W-1:0]),
      .ci        (sw_ci),
      .sub       (sw_sub),
      .out_valid (v_o),
      .out_ready (1'b1),
      .s         (s_o),
      .co        (co_o),
      .ov        (ov_o)
    );

    always @(negedge clk) begin
      sb_t e;
      if (!reset) begin
        if (sw_valid && rdy_o) q.push_back('{ref_add(W, sw_a, sw_b, sw_ci, sw_sub), cyc + 1});
        if (v_o) begin
          if (q.size() == 0) begin
            check($sformatf("sw%0d_extra", gi), 128'(1), 128'(0));
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_res", gi), 128'({ov_o, co_o, s_o}),
                  128'({e.exp[65:64], e.exp[W-1:0]}));
            check($sformatf("sw%0d_lat", gi), 128'(cyc - e.acc + 1), 128'(S));
          end
        end
      end
    end

    always @(posedge sw_done) check($sformatf("sw%0d_drain", gi), 128'(q.size()), 128'(0));
  end

  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tci, input logic tsub, input logic [31:0] es,
                         input logic eco, input logic eov);
    int lat;
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(4));
    check({tag, "_s"}, 128'(s), 128'(es));
    check({tag, "_co"}, 128'(co), 128'(eco));
    check({tag, "_ov"}, 128'(ov), 128'(eov));
    @(posedge clk); #1;
  endtask

  task automatic drive_rand();
    a = $urandom; b = $urandom;
    ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (mq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'(mq.size()), 128'(0));
  endtask

  initial begin
    int gaps;
    int stale;
    int n0;
    logic [33:0] hold;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_s", 128'(s), 128'(0));
    check("rst_co", 128'(co), 128'(0));
    check("rst_ov", 128'(ov), 128'(0));
    reset = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    run_one("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("sub_bin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);
    run_one("add_cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one("min_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Back-to-back stream
    gaps = 0;
    n0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      drive_rand();
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (i >= 3 && !out_valid) gaps++;
    end
    in_valid = 1'b0;
    check("stream_gaps", 128'(gaps), 128'(0));
    wait_drain("stream_drain");
    check("stream_count", 128'(n_out - n0), 128'(1000));

    // Backpressure with a full pipeline
    n0 = n_out;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_full", 128'(out_valid), 128'(1));
    out_ready = 1'b0;
    hold = {ov, co, s};
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      @(posedge clk); #1;
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_hold", 128'({ov, co, s}), 128'(hold));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    wait_drain("bp_drain");
    check("bp_count", 128'(n_out - n0), 128'(6));

    // Reset with operations in flight
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_0000 * (i + 1); b = 32'h0123_4567; ci = 1'b1; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 128'(out_valid), 128'(0));
    check("rst_async_s", 128'(s), 128'(0));
    check("rst_async_co", 128'(co), 128'(0));
    mq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_rel_ready", 128'(in_ready), 128'(1));
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_stale", 128'(stale), 128'(0));
    check("rst_no_out", 128'(n_out - n0), 128'(0));

    run_one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Width/stage sweep with random bubbles
    for (int i = 0; i < 300; i++) begin
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      sw_ci = 1'($urandom_range(0, 1));
      sw_sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    sw_done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cla_add.md
PIPE_CLA_ADD -- requirements
Module: pipe_cla_add

Interface
REQ-001 SHALL provide parameter WIDTH, default 32; operand width, a multiple of 4, range 8..128.
REQ-002 SHALL provide parameter STAGES, default 4; number of pipeline register stages, range 1..WIDTH/4.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL provide port reset, input, 1; reset SHALL be asynchronous and active-high.
REQ-005 SHALL provide port in_valid, input, 1: operands present.
REQ-006 SHALL provide port in_ready, output, 1: the block accepts operands this cycle.
REQ-007 SHALL provide ports a and b, each input, WIDTH: operands.
REQ-008 SHALL provide port ci, input, 1: carry-in for add, or borrow-in for subtract.
REQ-009 SHALL provide port sub, input, 1: 0 selects add, 1 selects subtract.
REQ-010 SHALL provide port out_valid, output, 1: result present.
REQ-011 SHALL provide port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL provide port s, output, WIDTH: sum or difference.
REQ-013 SHALL provide port co, output, 1: carry-out for add, or NOT borrow-out for subtract.
REQ-014 SHALL provide port ov, output, 1: two's-complement signed overflow.

Function
REQ-015 Arithmetic SHALL be:
- add: {co,s} = a + b + ci;
- subtract: {co,s} = a + ~b + ~ci, i.e. a - b - ci, with co=1 meaning no borrow.
REQ-016 ov SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-017 The datapath SHALL be split into N=WIDTH/4 nibble slices, each a 4-bit carry-lookahead unit with internal generate/propagate.
REQ-018 Slice k SHALL be evaluated in stage floor(k*STAGES/N).
- Carry between stages SHALL be registered.
- Carry between slices within a stage SHALL ripple combinationally.
REQ-019 Operand bits not yet consumed SHALL be carried forward in pipeline registers; result bits already produced SHALL be delayed to align.
REQ-020 Pipeline enable adv SHALL equal NOT (out_valid AND NOT out_ready).
- in_ready SHALL equal adv.
- All stages SHALL shift only when adv=1.
REQ-021 An input SHALL be accepted when in_valid AND in_ready; a per-stage valid bit SHALL travel with its data.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready is held at 1.
REQ-023 Throughput SHALL be one operation per cycle with no bubbles while out_ready=1.
REQ-024 While out_valid=1 and out_ready=0:
- s, co, ov and out_valid SHALL hold stable;
- no input SHALL be accepted;
- no data SHALL be lost or duplicated.
REQ-025 Bubbles (in_valid=0 cycles) SHALL propagate as valid=0 stages and SHALL NOT be compressed.
REQ-026 sub and ci SHALL be captured with their operands; changing them mid-flight SHALL NOT affect earlier operations.
REQ-027 Wrap-around: 0xFFFFFFFF+1 (WIDTH=32) SHALL produce s=0, co=1, ov=0.
REQ-028 When STAGES=1, the block SHALL be a fully registered single-cycle adder with latency 1.

Reset
REQ-029 While reset=1, all valid bits, s, co and ov SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Assertion of reset mid-operation SHALL discard all in-flight operations; none SHALL reappear after release.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold:
- the default WIDTH and STAGES constants;
- the slice width constant (4);
- a function mapping slice index to stage index.
REQ-033 The 4-bit lookahead slice SHALL be a sub-module named cla4_slice, with ports a[3:0], b[3:0], ci, s[3:0], co and c3 (carry into bit 3, used for ov).
REQ-034 Stage registers SHALL be built with a generate loop over STAGES; no vendor primitives SHALL be used.

Verification
REQ-035 Add with WIDTH=32, STAGES=4: a=0x7FFFFFFF, b=1, ci=0, sub=0 -> after 4 cycles s=0x80000000, co=0, ov=1.
REQ-036 Subtract: a=5, b=7, ci=0, sub=1 -> s=0xFFFFFFFE, co=0, ov=0; then a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, co=1, ov=1.
REQ-037 Back-to-back stream: 1000 random operations, out_ready=1 -> one result per cycle, in order, all matching the reference model.
REQ-038 Backpressure: out_ready held at 0 for 5 cycles while the pipeline is full -> in_ready=0, outputs stable, all results delivered in order after release.
REQ-039 Reset for 1 cycle with 3 operations in flight -> out_valid=0 immediately and thereafter until a new input is accepted; no stale results appear.
REQ-040 Parameter sweep over WIDTH in {8, 32, 64} and STAGES in {1, 2, WIDTH/4} -> latency equals STAGES and random results match the reference model.
